updown_mod_counter: RTL

//   Synchronous, parametrised up/down counter. Supersedes the 3-bit ripple

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_limit_detect.sv | 23 ++
 rtl/updown_mod_counter.sv | 88 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction encodings and a sizing helper.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int unsigned clog2_f(input longint unsigned value);
    int unsigned bits;
    bits = 1;
    while ((64'd1 << bits) < value) begin
      bits++;
    end
    return bits;
  endfunction

endpackage

// File: rtl/counter_limit_detect.sv
// Combinational limit detection for a modulo counter; also used by the timer blocks.
module counter_limit_detect
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             en,
  output logic             at_max,
  output logic             at_min,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

  assign at_max = (count == MaxCount);
  assign at_min = (count == '0);
  // Asserted in the cycle before a limit step so a cascaded stage can step on the same edge.
  assign tc     = en & ((up_dn == DIR_UP) ? at_max : at_min);

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulo counter with parallel load, enable and wrap/saturate mode.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 2 ** WIDTH,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2) begin : gen_bad_width
    $error("updown_mod_counter: WIDTH must be >= 2");
  end
  if ((MODULUS < 2) || (longint'(MODULUS) > (64'd1 << WIDTH))) begin : gen_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (SATURATE > 1) begin : gen_bad_saturate
    $error("updown_mod_counter: SATURATE must be 0 or 1");
  end

  // WIDTH+1 bits so MODULUS == 2**WIDTH is representable for the load clamp.
  localparam logic [WIDTH:0]   ModExt   = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);
  localparam logic             SatMode  = (SATURATE == 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_min;

  counter_limit_detect #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_limit (
    .count (count_q),
    .up_dn (up_dn),
    .en    (en),
    .at_max(at_max),
    .at_min(at_min),
    .tc    (tc)
  );

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = ({1'b0, load_val} >= ModExt) ? MaxCount : load_val;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (at_max) begin
          wrap_d  = 1'b1;
          count_d = SatMode ? count_q : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          wrap_d  = 1'b1;
          count_d = SatMode ? count_q : MaxCount;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
